// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: bytes are queued in a small FIFO and sent one bit per clk
// as start, 8 data bits (LSB first), parity and stop bit, with an optional parity fault.
module serial_frame_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          i_valid,
  input  logic [7:0]                    i_data,
  input  logic                          i_inj_err,
  output logic                          o_ready,
  output logic                          o_serial,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic ODD    = 1'(ODD_PARITY);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t        state;
  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  logic [8:0]    head;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          parity;
  logic [GW-1:0] gap_cnt;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign o_ready      = rstn && (count < CW'(FIFO_DEPTH));
  assign push         = i_valid && o_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign head         = mem[rd_ptr];
  assign o_fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_inj_err, i_data};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are loaded with the value belonging to the state being entered,
  // so the line changes exactly at the edge that moves the FSM.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      parity   <= 1'b0;
      gap_cnt  <= '0;
      o_serial <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_serial <= 1'b0;
          if (pop) begin
            shift    <= head[7:0];
            parity   <= (^head[7:0]) ^ head[8] ^ ODD;
            state    <= START;
            o_serial <= 1'b1;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          state    <= DATA;
          o_serial <= shift[0];
          shift    <= {1'b0, shift[7:1]};
          bit_cnt  <= '0;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            state    <= PARITY;
            o_serial <= parity;
          end else begin
            o_serial <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          state    <= STOP;
          o_serial <= 1'b0;
          o_done   <= 1'b1;
        end
        STOP: begin
          o_serial <= 1'b0;
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        GAP: begin
          o_serial <= 1'b0;
          if (gap_cnt == GW'(GAP_LAST)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          o_serial <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter that feeds the FSM-based serial data receiver. Bytes arrive on a valid/ready handshake into a small FIFO. Each byte is serialised at one bit per clk as an 11-bit frame: start bit, 8 data bits LSB first, parity bit, stop bit. A frame can carry a deliberately corrupted parity bit, so the receiver's error path can be exercised.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, at least 2.
- GAP_CYCLES, 1, minimum idle-level cycles after each stop bit before the next start bit; at least 0.
- ODD_PARITY, 0, 0 gives even parity (parity bit = XOR of data bits), 1 gives odd (inverted XOR).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- i_valid  in  1  upstream byte valid.
- i_data  in  8  byte to send.
- i_inj_err  in  1  sampled with i_data on push; when 1, the frame's parity bit is inverted.
- o_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH) and not in reset.
- o_serial  out  1  registered serial line; idle level 0.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse while the stop bit is driven.
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Push: when i_valid && o_ready at an edge, {i_inj_err, i_data} is written to the FIFO. Upstream must hold i_valid/i_data until accepted.
- Line encoding:
  - idle 0; start bit 1; data bits LSB first; stop bit 0.
  - parity = ^data ^ ODD_PARITY ^ inj_err.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE: if FIFO not empty, pop into the shift register and go to START; otherwise stay.
  - START: drive 1 for 1 cycle, then DATA with bit counter = 0.
  - DATA: drive shift[0], shift right, counter +1; after counter 7, go to PARITY.
  - PARITY: drive the computed parity for 1 cycle, then STOP.
  - STOP: drive 0, pulse o_done, then GAP if GAP_CYCLES > 0, else IDLE.
  - GAP: drive 0 for GAP_CYCLES cycles, then IDLE.
- Parity is computed from the popped byte at pop time, not from the shifting register.
- o_serial is a register loaded from the next-state value. Outside START/DATA/PARITY it is 0.
- FIFO rules:
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
  - Full: o_ready is 0 and the push is ignored, even if a pop occurs that cycle.
  - Empty: no pop.
- Reset (rstn low at an edge, including mid-frame):
  - State IDLE, FIFO emptied, counters cleared.
  - o_serial 0, o_busy 0, o_done 0, o_fifo_count 0, o_ready 0.
  - The frame in progress is abandoned, not completed.

## Timing
- Push at edge k into an empty FIFO with the FSM in IDLE:
  - o_fifo_count = 1 after edge k.
  - Pop at edge k+1; o_serial = 1 (start) after edge k+1; count returns to 0.
  - Data bit i follows edge k+2+i; parity after edge k+10; stop and o_done after edge k+11.
- Frame length is 11 cycles. Start-to-start spacing for back-to-back bytes is 11 + GAP_CYCLES + 1 cycles (+1 for the IDLE pop cycle).
- o_ready drops in the cycle after the push that fills the FIFO. It rises in the cycle after a pop from full.
- After rstn is released, o_ready is 1 at the first edge with rstn high.

## Test plan
- Single byte 0xA5, defaults -> o_serial sequence after start: 1, then 1,0,1,0,0,1,0,1, parity 0, stop 0; o_done pulses once; o_busy low again 2 cycles after the stop bit.
- Byte 0x07 with i_inj_err=1 (even parity expected 1) -> parity bit 0; in the next frame, 0x07 with i_inj_err=0 -> parity bit 1.
- ODD_PARITY=1, byte 0xA5 -> parity bit 1; byte 0xFF -> parity bit 1.
- Hold i_valid high for 6 consecutive bytes 0x01..0x06 with FIFO_DEPTH=4:
  - o_ready deasserts once count reaches 4.
  - Exactly 6 frames are sent in order.
  - Start bits are 13 cycles apart.
  - o_fifo_count never exceeds 4.
- Push and pop in the same cycle with count = 2 -> count stays 2.
- Reset asserted during data bit 3 of 0x3C with 2 bytes queued:
  - o_serial 0 and o_fifo_count 0 after the edge.
  - No further start bits after rstn is released until a new push occurs.
